// File: rtl/aud_recorder_stereo.sv
// I2S / left-justified serial ADC capture for a stereo (or left-only) stream.
// All logic runs on the audio bit clock and uses no divided clocks.
module aud_recorder_stereo #(
    parameter int DATA_W = 16,
    parameter int STEREO = 1,
    parameter int FMT    = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_lrc,
    input  logic              i_data,
    output logic [DATA_W-1:0] o_left,
    output logic [DATA_W-1:0] o_right,
    output logic              o_valid,
    output logic              o_short,
    output logic              o_busy
);
    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, WAIT_FRAME, SKIP, CAPTURE, DRAIN} state_t;

    state_t            state;
    logic              lrc_p;
    logic              channel;
    logic [CW-1:0]     cnt;
    logic [DATA_W-2:0] shift;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] word;

    logic fall, rise, opp, last;
    logic abort, start, start_skip, start_ch;

    assign fall   = lrc_p & ~i_lrc;
    assign rise   = ~lrc_p & i_lrc;
    assign opp    = channel ? fall : rise;
    assign last   = (state == CAPTURE) && (cnt == CW'(DATA_W - 1));
    assign word   = {shift, i_data};
    assign o_busy = (state != IDLE);

    always_comb begin
        abort      = 1'b0;
        start      = 1'b0;
        start_skip = (FMT == 0);
        start_ch   = 1'b0;
        case (state)
            WAIT_FRAME: start = fall;
            SKIP: begin
                abort = fall | rise;
                start = fall;
            end
            CAPTURE: begin
                if (last) begin
                    // Edge coincides with the final bit: this cycle's bit belongs to
                    // the finished word, so the next channel's MSB comes one cycle later.
                    start      = opp && (channel || STEREO != 0);
                    start_ch   = ~channel;
                    start_skip = 1'b1;
                end else begin
                    abort = fall | rise;
                    start = fall;
                end
            end
            DRAIN: begin
                start    = opp && (channel || STEREO != 0);
                start_ch = ~channel;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= IDLE;
            lrc_p   <= 1'b0;
            channel <= 1'b0;
            cnt     <= '0;
            shift   <= '0;
            hold    <= '0;
            o_left  <= '0;
            o_right <= '0;
            o_valid <= 1'b0;
            o_short <= 1'b0;
        end else begin
            lrc_p   <= i_lrc;
            o_valid <= 1'b0;
            o_short <= 1'b0;
            if (!i_en) begin
                state   <= IDLE;
                channel <= 1'b0;
                cnt     <= '0;
                shift   <= '0;
                hold    <= '0;
            end else if (state == IDLE) begin
                state <= WAIT_FRAME;
            end else begin
                if (last) begin
                    if (STEREO == 0) begin
                        o_left  <= word;
                        o_valid <= 1'b1;
                    end else if (!channel) begin
                        hold <= word;
                    end else begin
                        o_left  <= hold;
                        o_right <= word;
                        o_valid <= 1'b1;
                    end
                end
                if (start) begin
                    channel <= start_ch;
                    if (start_skip) begin
                        state <= SKIP;
                        cnt   <= '0;
                        shift <= '0;
                    end else begin
                        state <= CAPTURE;
                        cnt   <= CW'(1);
                        shift <= {{(DATA_W-2){1'b0}}, i_data};
                    end
                    if (abort) begin
                        o_short <= 1'b1;
                        hold    <= '0;
                    end
                end else if (abort) begin
                    o_short <= 1'b1;
                    hold    <= '0;
                    shift   <= '0;
                    cnt     <= '0;
                    state   <= WAIT_FRAME;
                end else begin
                    case (state)
                        SKIP: begin
                            shift <= {{(DATA_W-2){1'b0}}, i_data};
                            cnt   <= CW'(1);
                            state <= CAPTURE;
                        end
                        CAPTURE: begin
                            shift <= word[DATA_W-2:0];
                            cnt   <= cnt + CW'(1);
                            if (last) begin
                                state <= DRAIN;
                                // Left-only mode: remember we are in the ignored right slot.
                                if (opp && !channel) channel <= 1'b1;
                            end
                        end
                        DRAIN: if (rise && !channel) channel <= 1'b1;
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_aud_recorder_stereo.sv
// Directed bench for aud_recorder_stereo: four configurations share the serial
// stimulus, each with its own enable and expected-sample queue.
module tb_aud_recorder_stereo;
    typedef struct packed {
        logic [31:0] l;
        logic [31:0] r;
    } pair_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] en;
    logic       lrc;
    logic       data;

    logic [15:0] l0, r0, l1, r1, l3, r3;
    logic [23:0] l2, r2;
    logic [3:0]  valid, short_p, busy;

    int    n_pass = 0;
    int    n_total = 0;
    int    short_cnt [4] = '{0, 0, 0, 0};
    pair_t exp_q [4][$];

    logic [15:0] tl [3];
    logic [15:0] tr [3];

    aud_recorder_stereo #(.DATA_W(16), .STEREO(1), .FMT(0)) u_i2s (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .i_lrc(lrc), .i_data(data),
        .o_left(l0), .o_right(r0), .o_valid(valid[0]), .o_short(short_p[0]), .o_busy(busy[0]));
    aud_recorder_stereo #(.DATA_W(16), .STEREO(1), .FMT(1)) u_lj (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .i_lrc(lrc), .i_data(data),
        .o_left(l1), .o_right(r1), .o_valid(valid[1]), .o_short(short_p[1]), .o_busy(busy[1]));
    aud_recorder_stereo #(.DATA_W(24), .STEREO(1), .FMT(0)) u_w24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[2]), .i_lrc(lrc), .i_data(data),
        .o_left(l2), .o_right(r2), .o_valid(valid[2]), .o_short(short_p[2]), .o_busy(busy[2]));
    aud_recorder_stereo #(.DATA_W(16), .STEREO(0), .FMT(0)) u_mono (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en[3]), .i_lrc(lrc), .i_data(data),
        .o_left(l3), .o_right(r3), .o_valid(valid[3]), .o_short(short_p[3]), .o_busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input int id, input logic [31:0] l, input logic [31:0] r);
        pair_t p;
        p.l = l;
        p.r = r;
        exp_q[id].push_back(p);
    endtask

    task automatic got(input int id, input logic [31:0] l, input logic [31:0] r);
        pair_t p;
        check($sformatf("dut%0d_valid_expected", id), 32'(exp_q[id].size() != 0), 32'd1);
        if (exp_q[id].size() != 0) begin
            p = exp_q[id].pop_front();
            check($sformatf("dut%0d_left", id), l, p.l);
            check($sformatf("dut%0d_right", id), r, p.r);
        end
    endtask

    // Scoreboard side: outputs are registered, so sampling on the falling edge is stable.
    always @(negedge clk) begin
        if (valid[0]) got(0, 32'(l0), 32'(r0));
        if (valid[1]) got(1, 32'(l1), 32'(r1));
        if (valid[2]) got(2, 32'(l2), 32'(r2));
        if (valid[3]) got(3, 32'(l3), 32'(r3));
        for (int k = 0; k < 4; k++) if (short_p[k]) short_cnt[k]++;
    end

    // Drive slot cycles j0..j1-1; a 16-bit word starts at slot cycle 'delay'.
    task automatic drive_slot(input logic lv, input logic [31:0] word, input int delay,
                              input int j0, input int j1);
        for (int j = j0; j < j1; j++) begin
            @(negedge clk);
            lrc  = lv;
            data = (j >= delay && j < delay + 16) ? word[15 - (j - delay)] : 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] l, input logic [31:0] r, input int delay, input int slot);
        drive_slot(1'b0, l, delay, 0, slot);
        drive_slot(1'b1, r, delay, 0, slot);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            data = 1'b0;
        end
    endtask

    initial begin
        tl = '{16'hA5C3, 16'h5A3C, 16'h0001};
        tr = '{16'h1234, 16'hEDCB, 16'h8000};
        rst_n = 1'b0;
        en    = 4'b0000;
        lrc   = 1'b1;
        data  = 1'b0;

        idle(3);
        check("rst_left", 32'(l0), 32'd0);
        check("rst_right", 32'(r0), 32'd0);
        check("rst_valid", 32'(valid[0]), 32'd0);
        check("rst_short", 32'(short_p[0]), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Standard I2S capture, 32-bit slots
        en[0] = 1'b1;
        idle(3);
        check("i2s_busy", 32'(busy[0]), 32'd1);
        for (int i = 0; i < 3; i++) begin
            expect_out(0, 32'(tl[i]), 32'(tr[i]));
            frame(32'(tl[i]), 32'(tr[i]), 1, 32);
        end
        // Left-justified stimulus into the I2S receiver is one bit off
        expect_out(0, 32'(16'(tl[0] << 1)), 32'(16'(tr[0] << 1)));
        frame(32'(tl[0]), 32'(tr[0]), 0, 32);
        idle(4);
        check("i2s_no_short", 32'(short_cnt[0]), 32'd0);
        en[0] = 1'b0;
        idle(2);
        check("i2s_idle_busy", 32'(busy[0]), 32'd0);
        check("i2s_hold_left", 32'(l0), 32'(16'(tl[0] << 1)));

        // Left-justified receiver, 32-bit then exact-fit 16-bit slots
        en[1] = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 32'(tl[i]), 32'(tr[i]));
            frame(32'(tl[i]), 32'(tr[i]), 0, 32);
        end
        expect_out(1, 32'(tl[0] >> 1), 32'(tr[0] >> 1));
        frame(32'(tl[0]), 32'(tr[0]), 1, 32);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, 32'(tl[i]), 32'(tr[i]));
            frame(32'(tl[i]), 32'(tr[i]), 0, 16);
        end
        idle(4);
        check("lj_no_short", 32'(short_cnt[1]), 32'd0);
        en[1] = 1'b0;

        // 24-bit words in 16-bit slots: each frame aborts in its left slot
        en[2] = 1'b1;
        idle(3);
        for (int i = 0; i < 3; i++) frame(32'(tl[i]), 32'(tr[i]), 1, 16);
        idle(4);
        check("w24_short_count", 32'(short_cnt[2]), 32'd3);
        check("w24_left", 32'(l2), 32'd0);
        check("w24_right", 32'(r2), 32'd0);
        en[2] = 1'b0;

        // Left-only capture
        en[3] = 1'b1;
        idle(3);
        for (int i = 0; i < 2; i++) begin
            expect_out(3, 32'h8001, 32'h0);
            frame(32'h8001, 32'hFFFF, 1, 32);
        end
        idle(4);
        check("mono_no_short", 32'(short_cnt[3]), 32'd0);
        en[3] = 1'b0;

        // Enable raised mid-right-slot: nothing until the next full frame
        drive_slot(1'b0, 32'hFFFF, 1, 0, 32);
        drive_slot(1'b1, 32'hBEEF, 1, 0, 10);
        en[0] = 1'b1;
        drive_slot(1'b1, 32'hBEEF, 1, 10, 32);
        expect_out(0, 32'h3C5A, 32'hC3A5);
        frame(32'h3C5A, 32'hC3A5, 1, 32);

        // Early rise inside the left word, then early fall inside the right word
        drive_slot(1'b0, 32'h7777, 1, 0, 10);
        drive_slot(1'b1, 32'h1111, 1, 0, 32);
        drive_slot(1'b0, 32'h2222, 1, 0, 32);
        drive_slot(1'b1, 32'h3333, 1, 0, 10);
        expect_out(0, 32'(tl[1]), 32'(tr[1]));
        frame(32'(tl[1]), 32'(tr[1]), 1, 32);
        idle(2);
        check("i2s_short_count", 32'(short_cnt[0]), 32'd2);

        // Reset pulse in the middle of a left word
        drive_slot(1'b0, 32'h6666, 1, 0, 8);
        rst_n = 1'b0;
        drive_slot(1'b0, 32'h6666, 1, 8, 10);
        rst_n = 1'b1;
        drive_slot(1'b0, 32'h6666, 1, 10, 32);
        drive_slot(1'b1, 32'h9999, 1, 0, 32);
        check("post_rst_left", 32'(l0), 32'd0);
        check("post_rst_right", 32'(r0), 32'd0);
        expect_out(0, 32'(tl[2]), 32'(tr[2]));
        frame(32'(tl[2]), 32'(tr[2]), 1, 32);

        // Enable dropped in the middle of a right word
        drive_slot(1'b0, 32'hABCD, 1, 0, 32);
        drive_slot(1'b1, 32'hDCBA, 1, 0, 8);
        en[0] = 1'b0;
        drive_slot(1'b1, 32'hDCBA, 1, 8, 32);
        check("en_drop_left", 32'(l0), 32'(tl[2]));
        check("en_drop_right", 32'(r0), 32'(tr[2]));
        check("en_drop_busy", 32'(busy[0]), 32'd0);
        en[0] = 1'b1;
        idle(2);
        expect_out(0, 32'(tl[0]), 32'(tr[0]));
        frame(32'(tl[0]), 32'(tr[0]), 1, 32);
        idle(4);

        for (int k = 0; k < 4; k++)
            check($sformatf("dut%0d_pending_left", k), 32'(exp_q[k].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
